sevenseg_scan_driver: RTL and testbench

Time-multiplexed driver for the 8-digit common-anode seven-segment display. It sits directly downstream of the debug-output mux: it consumes the 32-bit display word and produces the anode and segment pins. It replaces the inline anode/segment scan logic in the FPGA top. The block adds:
- a per-frame snapshot, so digits never tear mid-frame;
- leading-zero blanking;
- per-digit decimal points;
- PWM brightness;
- a one-cycle dead slot between digits to suppress ghosting.

---
 rtl/sevenseg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit owns a 9-cycle slot: one dead cycle (PRE, all anodes off) followed
// by 2^BR_W lit-subslots. Brightness is set by how many subslots are lit. All
// display inputs are captured once per frame, so a frame never tears.
//
// Ports:
//   clk_7seg    in   scan clock
//   Rst         in   synchronous active-high reset
//   value       in   display word, nibble d drives digit d
//   dp_mask     in   bit d lights the decimal point of digit d
//   blank_lz    in   1 = blank leading-zero digits (digit 0 is never blanked)
//   bright      in   brightness b, digit lit for b+1 subslots
//   an          out  anodes, active-low, an[d]=0 selects digit d
//   sev_out     out  segments {a,b,c,d,e,f,g}, active-low
//   dp          out  decimal point, active-low
//   frame_done  out  one-cycle pulse in the last cycle of each frame
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
   parameter int NDIG = 8,
   parameter int BR_W = 3
) (
   input  logic              clk_7seg,
   input  logic              Rst,
   input  logic [4*NDIG-1:0] value,
   input  logic [NDIG-1:0]   dp_mask,
   input  logic              blank_lz,
   input  logic [BR_W-1:0]   bright,
   output logic [NDIG-1:0]   an,
   output logic [6:0]        sev_out,
   output logic              dp,
   output logic              frame_done
);

   localparam int D_W = $clog2(NDIG);
   localparam int P_W = BR_W + 1;
   localparam logic [D_W-1:0] D_LAST = D_W'(NDIG - 1);
   localparam logic [P_W-1:0] P_LAST = P_W'(2 ** BR_W);

   // Hex digit to active-low segment pattern, bit order {a,b,c,d,e,f,g}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h01;
         4'h1:    seg = 7'h4F;
         4'h2:    seg = 7'h12;
         4'h3:    seg = 7'h06;
         4'h4:    seg = 7'h4C;
         4'h5:    seg = 7'h24;
         4'h6:    seg = 7'h20;
         4'h7:    seg = 7'h0F;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h04;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h60;
         4'hC:    seg = 7'h31;
         4'hD:    seg = 7'h42;
         4'hE:    seg = 7'h30;
         4'hF:    seg = 7'h38;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   logic [D_W-1:0]    d_r;
   logic [P_W-1:0]    p_r;
   logic [4*NDIG-1:0] value_snap_r;
   logic [NDIG-1:0]   dp_mask_snap_r;
   logic              blank_lz_snap_r;
   logic [BR_W-1:0]   bright_snap_r;

   logic [3:0]        nib_s;
   logic              blank_s;
   logic              lit_s;

   // Digit / phase scan counters: p runs 0..P_LAST, then the next digit starts.
   always_ff @(posedge clk_7seg) begin
      if (Rst) begin
         d_r <= '0;
         p_r <= '0;
      end else if (p_r == P_LAST) begin
         p_r <= '0;
         d_r <= (d_r == D_LAST) ? '0 : d_r + D_W'(1);
      end else begin
         p_r <= p_r + P_W'(1);
      end
   end

   // Frame snapshot: loaded at the end of the (d0, PRE) cycle so digit 0 already
   // sees the new frame's data; the rest of the frame ignores the inputs.
   always_ff @(posedge clk_7seg) begin
      if (Rst) begin
         value_snap_r    <= '0;
         dp_mask_snap_r  <= '0;
         blank_lz_snap_r <= 1'b0;
         bright_snap_r   <= '0;
      end else if ((d_r == '0) && (p_r == '0)) begin
         value_snap_r    <= value;
         dp_mask_snap_r  <= dp_mask;
         blank_lz_snap_r <= blank_lz;
         bright_snap_r   <= bright;
      end else begin
         value_snap_r    <= value_snap_r;
         dp_mask_snap_r  <= dp_mask_snap_r;
         blank_lz_snap_r <= blank_lz_snap_r;
         bright_snap_r   <= bright_snap_r;
      end
   end

   // Lit / blank qualification from counters and snapshot only.
   always_comb begin
      nib_s   = value_snap_r[{d_r, 2'b00} +: 4];
      blank_s = 1'b0;
      // A digit is a leading zero when it and every more-significant nibble
      // are zero; shifting the word down by 4*d leaves exactly those nibbles.
      if ((d_r != '0) && blank_lz_snap_r) begin
         blank_s = ((value_snap_r >> {d_r, 2'b00}) == {(4*NDIG){1'b0}});
      end else begin
         blank_s = 1'b0;
      end
      // Subslot s = p-1 is lit while s <= bright, i.e. p <= bright+1.
      lit_s = (p_r != '0)
              && (p_r <= ({1'b0, bright_snap_r} + P_W'(1)))
              && !blank_s;
   end

   // Pin decode: everything off unless the current digit is lit.
   always_comb begin
      an         = {NDIG{1'b1}};
      sev_out    = 7'h7F;
      dp         = 1'b1;
      frame_done = (d_r == D_LAST) && (p_r == P_LAST);
      if (lit_s) begin
         an      = ~(NDIG'(1) << d_r);
         sev_out = hex_to_seg(nib_s);
         dp      = ~dp_mask_snap_r[d_r];
      end else begin
         an      = {NDIG{1'b1}};
         sev_out = 7'h7F;
         dp      = 1'b1;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sevenseg_scan_driver. A frame-position model keeps
// its own snapshot of the inputs and predicts the pins for every cycle; each
// prediction is queued when the cycle is driven and popped when the DUT output
// for that cycle is sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

   logic        clk_7seg;
   logic        Rst;
   logic [31:0] value;
   logic [7:0]  dp_mask;
   logic        blank_lz;
   logic [2:0]  bright;
   logic [7:0]  an;
   logic [6:0]  sev_out;
   logic        dp;
   logic        frame_done;

   int vectors;
   int miscompares;

   // model state: position within the frame and the frame snapshot
   int          cyc;
   logic [31:0] s_val;
   logic [7:0]  s_dp;
   logic        s_blz;
   logic [2:0]  s_br;

   logic [16:0] sb[$];

   localparam logic [6:0] HEX_REF [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   sevenseg_scan_driver #(.NDIG(8), .BR_W(3)) dut (
      .clk_7seg   (clk_7seg),
      .Rst        (Rst),
      .value      (value),
      .dp_mask    (dp_mask),
      .blank_lz   (blank_lz),
      .bright     (bright),
      .an         (an),
      .sev_out    (sev_out),
      .dp         (dp),
      .frame_done (frame_done)
   );

   initial clk_7seg = 1'b0;
   always #5 clk_7seg = ~clk_7seg;

   // Expected {an, sev_out, dp, frame_done} for frame cycle c.
   function automatic logic [16:0] model_out(input int c);
      int          d;
      int          p;
      logic [31:0] upper;
      logic        lit;
      logic [7:0]  a;
      logic [6:0]  s;
      logic        dpo;
      d     = c / 9;
      p     = c % 9;
      upper = s_val >> (4 * d);
      lit   = (p >= 1) && ((p - 1) <= int'(s_br))
              && !((d >= 1) && s_blz && (upper == 32'd0));
      a   = 8'hFF;
      s   = 7'h7F;
      dpo = 1'b1;
      if (lit) begin
         a[d] = 1'b0;
         s    = HEX_REF[upper[3:0]];
         dpo  = ~s_dp[d];
      end
      return {a, s, dpo, (c == 71)};
   endfunction

   // One cycle: predict, compare, advance the model, move to the next sample.
   task automatic tick();
      logic [16:0] e;
      sb.push_back(model_out(cyc));
      e = sb.pop_front();
      vectors++;
      if ({an, sev_out, dp, frame_done} !== e) begin
         miscompares++;
         $display("FAIL scan cyc=%0d got an=%h sev=%h dp=%b fd=%b want an=%h sev=%h dp=%b fd=%b",
                  cyc, an, sev_out, dp, frame_done, e[16:9], e[8:2], e[1], e[0]);
      end
      if (cyc == 0) begin
         s_val = value;
         s_dp  = dp_mask;
         s_blz = blank_lz;
         s_br  = bright;
      end
      cyc = (cyc == 71) ? 0 : cyc + 1;
      @(negedge clk_7seg);
   endtask

   task automatic run_until(input int target);
      while (cyc != target) tick();
   endtask

   // Reset pulse; returns at the falling edge of the first reset cycle.
   task automatic apply_reset();
      Rst = 1'b1;
      @(posedge clk_7seg);
      @(negedge clk_7seg);
      vectors++;
      if ({an, sev_out, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_vals got an=%h sev=%h dp=%b fd=%b want an=ff sev=7f dp=1 fd=0",
                  an, sev_out, dp, frame_done);
      end
      sb.delete();
      cyc   = 0;
      s_val = 32'd0;
      s_dp  = 8'd0;
      s_blz = 1'b0;
      s_br  = 3'd0;
      Rst   = 1'b0;
   endtask

   task automatic test_reset();
      value    = 32'h12345678;
      dp_mask  = 8'h00;
      blank_lz = 1'b0;
      bright   = 3'd7;
      apply_reset();
   endtask

   task automatic test_normal_scan();
      for (int i = 0; i < 72; i++) begin
         vectors++;
         if (cyc >= 1 && cyc <= 8) begin
            if (an !== 8'hFE || sev_out !== 7'h00) begin
               miscompares++;
               $display("FAIL normal_d0 cyc=%0d got an=%h sev=%h want an=fe sev=00", cyc, an, sev_out);
            end
         end else if (cyc >= 64) begin
            if (an !== 8'h7F || sev_out !== 7'h4F) begin
               miscompares++;
               $display("FAIL normal_d7 cyc=%0d got an=%h sev=%h want an=7f sev=4f", cyc, an, sev_out);
            end
         end else if (cyc % 9 == 0) begin
            if (an !== 8'hFF) begin
               miscompares++;
               $display("FAIL normal_pre cyc=%0d got an=%h want an=ff", cyc, an);
            end
         end else begin
            if (frame_done !== 1'b0) begin
               miscompares++;
               $display("FAIL normal_fd cyc=%0d got fd=%b want fd=0", cyc, frame_done);
            end
         end
         tick();
      end
   endtask

   // Runs one aligned frame and counts lit, dp-lit and off-pattern cycles.
   task automatic frame_stats(input logic [6:0] want_sev, output int lit_n,
                              output int dp_n, output int sev_bad);
      lit_n = 0; dp_n = 0; sev_bad = 0;
      for (int i = 0; i < 72; i++) begin
         if (an !== 8'hFF) begin
            lit_n++;
            if (sev_out !== want_sev) sev_bad++;
         end
         if (dp === 1'b0) dp_n++;
         tick();
      end
   endtask

   task automatic check_count(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic test_brightness();
      int l, dn, sbad;
      value = 32'd0; bright = 3'd0; blank_lz = 1'b0; dp_mask = 8'h00;
      run_until(0);
      frame_stats(7'h01, l, dn, sbad);
      check_count("bright0_lit", l, 8);
      check_count("bright0_sev", sbad, 0);
      bright = 3'd3;
      frame_stats(7'h01, l, dn, sbad);
      check_count("bright3_lit", l, 32);
   endtask

   task automatic test_blanking();
      int l, dn, sbad;
      value = 32'h000000A0; blank_lz = 1'b1; bright = 3'd7; dp_mask = 8'h00;
      run_until(0);
      frame_stats(7'h7F, l, dn, sbad);
      check_count("blank_a0_lit", l, 16);
      value = 32'd0;
      frame_stats(7'h01, l, dn, sbad);
      check_count("blank_zero_lit", l, 8);
      check_count("blank_zero_sev", sbad, 0);
   endtask

   task automatic test_snapshot();
      value = 32'h11111111; blank_lz = 1'b0; bright = 3'd7; dp_mask = 8'h00;
      run_until(0);
      for (int i = 0; i < 72; i++) begin
         if (cyc == 30) value = 32'h22222222;
         if (cyc > 30 && an !== 8'hFF) begin
            vectors++;
            if (sev_out !== 7'h4F) begin
               miscompares++;
               $display("FAIL snap_hold cyc=%0d got sev=%h want sev=4f", cyc, sev_out);
            end
         end
         tick();
      end
      for (int i = 0; i < 72; i++) begin
         if (an !== 8'hFF) begin
            vectors++;
            if (sev_out !== 7'h12) begin
               miscompares++;
               $display("FAIL snap_next cyc=%0d got sev=%h want sev=12", cyc, sev_out);
            end
         end
         tick();
      end
   endtask

   task automatic test_decimal_point();
      int l, dn, sbad;
      value = 32'h12345678; dp_mask = 8'h04; blank_lz = 1'b0; bright = 3'd7;
      run_until(0);
      for (int i = 0; i < 72; i++) begin
         vectors++;
         if (dp !== ((cyc >= 19 && cyc <= 26) ? 1'b0 : 1'b1)) begin
            miscompares++;
            $display("FAIL dp_digit2 cyc=%0d got dp=%b", cyc, dp);
         end
         tick();
      end
      blank_lz = 1'b1; value = 32'd0;
      frame_stats(7'h01, l, dn, sbad);
      check_count("dp_blanked", dn, 0);
   endtask

   task automatic test_reset_mid_frame();
      value = 32'h12345678; dp_mask = 8'h00; blank_lz = 1'b0; bright = 3'd7;
      run_until(0);
      run_until(40);
      Rst = 1'b1;
      tick();
      vectors++;
      if ({an, sev_out, frame_done} !== {8'hFF, 7'h7F, 1'b0}) begin
         miscompares++;
         $display("FAIL midreset_vals got an=%h sev=%h fd=%b want an=ff sev=7f fd=0",
                  an, sev_out, frame_done);
      end
      sb.delete();
      cyc = 0; s_val = 32'd0; s_dp = 8'd0; s_blz = 1'b0; s_br = 3'd0;
      Rst = 1'b0;
      tick();
      vectors++;
      if (an !== 8'hFE || sev_out !== 7'h00) begin
         miscompares++;
         $display("FAIL midreset_first got an=%h sev=%h want an=fe sev=00", an, sev_out);
      end
      run_until(0);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 4; f++) begin
         value    = $urandom;
         dp_mask  = 8'($urandom_range(0, 255));
         blank_lz = 1'($urandom_range(0, 1));
         bright   = 3'($urandom_range(0, 7));
         if (f == 1) value = 32'h00000F00;
         run_until(71);
         tick();
      end
      run_until(0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      Rst = 1'b1; value = 32'd0; dp_mask = 8'd0; blank_lz = 1'b0; bright = 3'd0;
      cyc = 0; s_val = 32'd0; s_dp = 8'd0; s_blz = 1'b0; s_br = 3'd0;
      test_reset();
      test_normal_scan();
      test_brightness();
      test_blanking();
      test_snapshot();
      test_decimal_point();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
